// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor
//   Bit-serial subtractor: computes A - B - Bin over WIDTH clock cycles,
//   one bit per cycle, LSB first, using a single full-subtractor cell and a
//   one-bit borrow register carried from cycle to cycle.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request pulse, accepted whenever busy=0 (IDLE or DONE)
//   A, B   minuend / subtrahend, sampled on the accepting edge
//   Bin    borrow-in, sampled on the accepting edge
//   busy   high while the operation is running (RUN state)
//   done   one-cycle pulse in the cycle Diff/Bout carry a fresh result
//   Diff   registered (A - B - Bin) mod 2^WIDTH
//   Bout   registered final borrow-out (1 = result went negative)
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] part;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] part_next;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic bi);
    logic dd;
    logic bo;
    dd = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
    return {bo, dd};
  endfunction

  assign {br_next, d} = sub_cell(a_sr[0], b_sr[0], br);

  // start is honoured in IDLE and in DONE (back-to-back), never in RUN.
  assign accept    = start && (state != RUN);
  assign last      = (state == RUN) && (cnt == LAST);
  assign part_next = {d, part[WIDTH-1:1]};

  // busy/done decode the state register only; no path from start.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/partial shift registers, borrow, counter and result registers.
  // The result is written only on the edge that processes the final bit,
  // so Diff/Bout hold through IDLE and RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      part <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      Diff <= '0;
      Bout <= 1'b0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      br   <= Bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      br   <= br_next;
      part <= part_next;
      cnt  <= cnt + 1'b1;
      if (last) begin
        Diff <= part_next;
        Bout <= br_next;
      end
    end
  end

endmodule
